tt_scanner: RTL and testbench
=============================

TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 SETTLE, default 2, number of cycles each input code is held before sampling; the legal range SHALL be 1..15.
REQ-002 EXP_TABLE, default 16'hAC3C, expected 16-entry truth table; bit i SHALL be the expected s for code i, with code = {a,b,c,d}.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-006 s_in  input  1  output of the downstream 4-input function under test.
REQ-007 a, b, c, d  output  1 each  registered stimulus; a is the MSB of the code and d is the LSB.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the scan completes.
REQ-010 table  output  16  captured truth table; bit i holds s_in as sampled for code i.
REQ-011 match  output  1  table equals EXP_TABLE (see Configuration).
REQ-012 first_err  output  4  lowest code whose captured bit differs from EXP_TABLE; 0 when match is high.

Function
REQ-013 The FSM SHALL have exactly four states, IDLE, DRIVE, SAMPLE and DONE, encoded in 2 bits.
REQ-014 IDLE→DRIVE on the edge where start=1; this edge SHALL also clear code to 0, clear the settle count and clear table.
REQ-015 The FSM SHALL stay in DRIVE for exactly SETTLE cycles, with {a,b,c,d}=code held stable throughout, then move to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle and write table[code]<=s_in at its closing edge.
  - code<15: code increments and the FSM returns to DRIVE.
  - code=15: the FSM moves to DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE; there is no wrap-around to code 0.
REQ-018 Scan latency: done SHALL be high during cycle 16*(SETTLE+1)+1 counted from the start edge (49 when SETTLE=2).
REQ-019 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-020 start asserted in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-021 table, match and first_err SHALL hold their values in IDLE until the next accepted start.
REQ-022 match and first_err SHALL be updated combinationally from table and SHALL be meaningful when done=1.
REQ-023 The stimulus outputs SHALL keep the last driven code (4'b1111) in DONE and IDLE after a scan.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, code=0, settle count=0, table=0, a=b=c=d=0, busy=0, done=0.
REQ-025 Reset asserted mid-scan SHALL abort the scan with no done pulse; a new start is then required.
REQ-026 Under reset with TT_SCANNER_CHECK_EN defined, match SHALL equal (EXP_TABLE==0).

Configuration
REQ-027 With macro TT_SCANNER_CHECK_EN defined, the comparison logic SHALL be compiled in and match/first_err SHALL behave per REQ-011, REQ-012 and REQ-022.
REQ-028 With TT_SCANNER_CHECK_EN undefined, the comparison logic SHALL be absent and match and first_err SHALL be tied to 0; all other behaviour SHALL be unchanged.

Structure
REQ-029 Package tt_pkg SHALL hold the state enum type, CODE_W=4, TABLE_W=16 and the default EXP_TABLE constant.
REQ-030 The settle counter SHALL be a sub-module, tt_settle_cnt: a loadable down-counter with a zero flag.
REQ-031 The top level SHALL contain only the FSM, the code register, the table register and the optional compare logic.

Verification
REQ-032 Reset, then start with SETTLE=2 and s_in driven by the reference function → done in cycle 49, table=16'hAC3C, match=1, first_err=0.
REQ-033 Same as REQ-032 but with s_in forced to 0 only when code=5 → table=16'hAC1C, match=0, first_err=5.
REQ-034 start pulsed repeatedly while busy=1 → exactly one done pulse, at cycle 49.
REQ-035 rst asserted at cycle 20 of a scan → busy=0, table=0, {a,b,c,d}=0 immediately, with no done pulse; a new start then completes normally.
REQ-036 SETTLE=1 → done at cycle 33; {a,b,c,d} steps 0→15, each code held for 2 cycles.
REQ-037 Build without TT_SCANNER_CHECK_EN and run REQ-032 → table=16'hAC3C, match=0, first_err=0.

Source files
------------

// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared types and constants for the truth-table scanner slice.
//   tt_state_t        : scanner FSM states, 2-bit encoding
//   CODE_W            : width of the stimulus code {a,b,c,d}
//   TABLE_W           : number of truth-table entries (2**CODE_W)
//   SETTLE_W          : width of the settle counter (holds 0..15)
//   EXP_TABLE_DEFAULT : reference truth table the scanner compares against
// -----------------------------------------------------------------------------
package tt_pkg;

    localparam int CODE_W   = 4;
    localparam int TABLE_W  = 16;
    localparam int SETTLE_W = 4;

    localparam logic [TABLE_W-1:0] EXP_TABLE_DEFAULT = 16'hAC3C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_t;

endpackage

// File: rtl/tt_settle_cnt.sv
// -----------------------------------------------------------------------------
// tt_settle_cnt
// Loadable down-counter with a zero flag, used to time how long each stimulus
// code is held before the response is sampled.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   zero     : high when the count is zero
// -----------------------------------------------------------------------------
module tt_settle_cnt
    import tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    // Load wins over decrement; decrementing at zero holds, so the counter
    // can never wrap and stretch a settle window by accident.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tt_scanner.sv
// -----------------------------------------------------------------------------
// tt_scanner
// Walks a 4-input combinational function through all 16 input codes, holds
// each code for SETTLE cycles, samples the response and builds its truth
// table. Optionally compares the captured table against EXP_TABLE.
//
// Build option:
//   TT_SCANNER_CHECK_EN : when defined, compare logic drives match/first_err;
//                         when undefined, match and first_err are tied to 0.
//
// Parameters:
//   SETTLE    : cycles each code is held before sampling (legal 1..15)
//   EXP_TABLE : expected truth table, bit i is the expected response to code i
//
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   start       : one-cycle scan request, only honoured in IDLE
//   s_in        : response of the function under test
//   a, b, c, d  : registered stimulus code, a is the MSB, d the LSB
//   busy        : high whenever the scanner is not IDLE
//   done        : one-cycle pulse in the final scan cycle
//   truth_table : captured table, bit i is s_in sampled for code i
//                 ("table" itself is a reserved word, hence the longer name)
//   match       : captured table equals EXP_TABLE
//   first_err   : lowest code whose captured bit disagrees, 0 on a match
// -----------------------------------------------------------------------------
module tt_scanner
    import tt_pkg::*;
#(
    parameter int                 SETTLE    = 2,
    parameter logic [TABLE_W-1:0] EXP_TABLE = EXP_TABLE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               s_in,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] truth_table,
    output logic               match,
    output logic [CODE_W-1:0]  first_err
);

    // The counter is loaded with SETTLE-1 and the FSM leaves DRIVE in the
    // cycle where it reads zero, which gives exactly SETTLE DRIVE cycles.
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
    localparam logic [CODE_W-1:0]   LAST_CODE   = '1;

    tt_state_t           state;
    tt_state_t           next_state;
    logic [CODE_W-1:0]   code;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;

    tt_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and counter control. The settle window is re-armed on every
    // edge that enters DRIVE, so each code gets a fresh SETTLE-cycle hold.
    // The counter is already zero whenever the FSM is idle (it only leaves
    // DRIVE at zero, and reset clears it), so a new scan starts from a clean
    // count.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_DRIVE;
                    cnt_load   = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_zero) begin
                    next_state = ST_SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (code == LAST_CODE) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_DRIVE;
                    cnt_load   = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Code and table registers. An accepted start wipes the previous result;
    // the closing edge of SAMPLE records the response and advances the code.
    // At the last code the code is left at 15 rather than wrapping, so the
    // stimulus pins keep showing the final code after the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code        <= '0;
            truth_table <= '0;
        end else if ((state == ST_IDLE) && start) begin
            code        <= '0;
            truth_table <= '0;
        end else if (state == ST_SAMPLE) begin
            truth_table[code] <= s_in;
            if (code != LAST_CODE) begin
                code <= code + CODE_W'(1);
            end
        end
    end

    assign {a, b, c, d} = code;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

`ifdef TT_SCANNER_CHECK_EN
    logic [TABLE_W-1:0] diff;

    assign diff  = truth_table ^ EXP_TABLE;
    assign match = (diff == '0);

    // Scan from the top entry down so the last hit is the lowest failing code.
    always_comb begin
        first_err = '0;
        for (int i = TABLE_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                first_err = CODE_W'(i);
            end
        end
    end
`else
    logic unused_exp_table;

    assign unused_exp_table = ^EXP_TABLE;
    assign match            = 1'b0;
    assign first_err        = '0;
`endif

endmodule

// File: tb/tb_tt_scanner.sv
// -----------------------------------------------------------------------------
// tb_tt_scanner
// Directed testbench for tt_scanner. Two instances are used: one with the
// default SETTLE=2 and one with SETTLE=1. Each instance's s_in is a reference
// model of the function 16'hAC3C, with an optional forced-zero fault at code 5.
// -----------------------------------------------------------------------------
module tb_tt_scanner;

`ifdef TT_SCANNER_CHECK_EN
    localparam bit CHECK_BUILT = 1'b1;
`else
    localparam bit CHECK_BUILT = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic        fault = 1'b0;
    logic [15:0] ref_tab = 16'hAC3C;

    int check_count = 0;
    int pass_count  = 0;

    // Instance A: SETTLE = 2
    logic        a_a, b_a, c_a, d_a, busy_a, done_a, match_a, s_in_a, start_a;
    logic [15:0] tab_a;
    logic [3:0]  ferr_a;
    logic [3:0]  code_a;

    // Instance B: SETTLE = 1
    logic        a_b, b_b, c_b, d_b, busy_b, done_b, match_b, s_in_b, start_b;
    logic [15:0] tab_b;
    logic [3:0]  ferr_b;
    logic [3:0]  code_b;

    assign code_a  = {a_a, b_a, c_a, d_a};
    assign code_b  = {a_b, b_b, c_b, d_b};
    assign s_in_a  = ref_tab[code_a] && !(fault && (code_a == 4'd5));
    assign s_in_b  = ref_tab[code_b] && !(fault && (code_b == 4'd5));
    assign start_a = start && !sel;
    assign start_b = start && sel;

    logic [3:0]  code_sel;
    logic        busy_sel, done_sel, match_sel;
    logic [15:0] tab_sel;
    logic [3:0]  ferr_sel;

    assign code_sel  = sel ? code_b  : code_a;
    assign busy_sel  = sel ? busy_b  : busy_a;
    assign done_sel  = sel ? done_b  : done_a;
    assign match_sel = sel ? match_b : match_a;
    assign tab_sel   = sel ? tab_b   : tab_a;
    assign ferr_sel  = sel ? ferr_b  : ferr_a;

    tt_scanner u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .s_in        (s_in_a),
        .a           (a_a),
        .b           (b_a),
        .c           (c_a),
        .d           (d_a),
        .busy        (busy_a),
        .done        (done_a),
        .truth_table (tab_a),
        .match       (match_a),
        .first_err   (ferr_a)
    );

    tt_scanner #(.SETTLE(1)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .s_in        (s_in_b),
        .a           (a_b),
        .b           (b_b),
        .c           (c_b),
        .d           (d_b),
        .busy        (busy_b),
        .done        (done_b),
        .truth_table (tab_b),
        .match       (match_b),
        .first_err   (ferr_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Issue a start to the selected instance, then watch run_cycles cycles.
    // Cycle n is the n-th cycle after the start edge; outputs are sampled at
    // the falling edge. Optional behaviours: repeated start pulses while busy,
    // a reset at cycle abort_at, and per-cycle checking of the stimulus code.
    task automatic applyStimulus(input bit use_b, input bit pulse_busy,
                                 input int abort_at, input bit check_codes,
                                 input int settle, input int run_cycles,
                                 output int done_cyc, output int done_cnt);
        done_cyc = 0;
        done_cnt = 0;
        sel      = use_b;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= run_cycles; n++) begin
            @(negedge clk);
            if (pulse_busy) begin
                if (n <= 49) begin
                    start = (n % 2) == 1;
                end else if (n == 50) begin
                    checkOutput("busy_after_done", busy_sel, 1'b0);
                    start = 1'b1;
                end else if (n == 51) begin
                    start = 1'b0;
                    checkOutput("restart_busy", busy_sel, 1'b1);
                    checkOutput("restart_code", code_sel, 4'd0);
                end
            end else begin
                start = 1'b0;
            end
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                checkOutput("abort_busy", busy_sel, 1'b0);
                checkOutput("abort_table", tab_sel, 16'h0000);
                checkOutput("abort_code", code_sel, 4'd0);
                checkOutput("abort_done", done_sel, 1'b0);
            end else if (n == abort_at + 1) begin
                rst = 1'b0;
            end
            if (check_codes && (n <= 16 * (settle + 1))) begin
                checkOutput($sformatf("code_c%0d", n), code_sel,
                            32'((n - 1) / (settle + 1)));
            end
            if (done_sel) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = n;
                end
            end
        end
        start = 1'b0;
    endtask

    int dc;
    int dn;

    initial begin
        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_code", code_a, 4'd0);
        checkOutput("rst_busy", busy_a, 1'b0);
        checkOutput("rst_done", done_a, 1'b0);
        checkOutput("rst_table", tab_a, 16'h0000);
        checkOutput("rst_match", match_a, 1'b0);
        checkOutput("rst_first_err", ferr_a, 4'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean scan with SETTLE=2, codes stepping every three cycles
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 2, 60, dc, dn);
        checkOutput("scan_done_cycle", dc, 49);
        checkOutput("scan_done_count", dn, 1);
        checkOutput("scan_table", tab_a, 16'hAC3C);
        checkOutput("scan_match", match_a, CHECK_BUILT ? 1'b1 : 1'b0);
        checkOutput("scan_first_err", ferr_a, 4'd0);
        checkOutput("scan_last_code", code_a, 4'hF);
        checkOutput("scan_busy_idle", busy_a, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("hold_table", tab_a, 16'hAC3C);
        checkOutput("hold_code", code_a, 4'hF);

        // Response forced low at code 5
        fault = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 2, 55, dc, dn);
        checkOutput("fault_done_cycle", dc, 49);
        checkOutput("fault_table", tab_a, 16'hAC1C);
        checkOutput("fault_match", match_a, 1'b0);
        checkOutput("fault_first_err", ferr_a, CHECK_BUILT ? 4'd5 : 4'd0);
        fault = 1'b0;

        // Start pulsed throughout the scan, then accepted in the first idle cycle
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 2, 55, dc, dn);
        checkOutput("pulse_done_cycle", dc, 49);
        checkOutput("pulse_done_count", dn, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset in cycle 20 aborts the scan without a done pulse
        applyStimulus(1'b0, 1'b0, 20, 1'b0, 2, 70, dc, dn);
        checkOutput("abort_done_count", dn, 0);
        checkOutput("abort_idle", busy_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 2, 55, dc, dn);
        checkOutput("rescan_done_cycle", dc, 49);
        checkOutput("rescan_table", tab_a, 16'hAC3C);

        // SETTLE=1 instance: each code held two cycles, done in cycle 33
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 1, 40, dc, dn);
        checkOutput("s1_done_cycle", dc, 33);
        checkOutput("s1_done_count", dn, 1);
        checkOutput("s1_table", tab_b, 16'hAC3C);
        checkOutput("s1_last_code", code_b, 4'hF);
        checkOutput("s1_match", match_b, CHECK_BUILT ? 1'b1 : 1'b0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
